// File: rtl/sync_fifo_stream_reader.sv
// Read-side drain engine: pulls a fixed number of words from a synchronous FIFO read
// port and replays them in order on a valid/ready stream through a 2-entry skid buffer.
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 18,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  clock0,
    input  logic                  rst_ptr_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  rd_count,
    output logic                  err_underrun,
    output logic                  fifo_re,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic                  fifo_underrun,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [1:0]            dbg_state_o
);
    // Stream handshake: a word moves when m_valid and m_ready are both high at a clock0
    // edge; once m_valid is high, m_data is held unchanged until that edge.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  delivered_q, delivered_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  err_q, err_d;
    logic                  pop;
    logic                  re;
    logic                  can_read;
    logic [2:0]            occupancy;

    assign pop       = (buf_cnt_q != 2'd0) && m_ready;
    assign occupancy = {1'b0, buf_cnt_q} + {2'b00, inflight_q};
    // Words already owed to the buffer, less the one leaving this cycle, must stay below 2.
    assign can_read  = !fifo_empty && (issued_q < len_q) &&
                       (occupancy < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        buf_cnt_d   = buf_cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        err_d       = err_q;
        re          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = len;
                    issued_d    = '0;
                    delivered_d = '0;
                    err_d       = 1'b0;
                    state_d     = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                re          = can_read && rst_ptr_n;
                issued_d    = issued_q + LEN_WIDTH'(re);
                delivered_d = delivered_q + LEN_WIDTH'(pop);
                if (fifo_underrun) begin
                    err_d = 1'b1;
                end
                if (delivered_d == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        inflight_d = re;

        // The word read last cycle lands behind whatever survives this cycle's pop.
        case ({inflight_q, pop})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    head_d = fifo_dout;
                end else begin
                    tail_d = fifo_dout;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                head_d    = tail_q;
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    head_d = fifo_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock0) begin
        if (!rst_ptr_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            buf_cnt_q   <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= inflight_d;
            buf_cnt_q   <= buf_cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            err_q       <= err_d;
        end
    end

    assign fifo_re      = re;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign rd_count     = delivered_q;
    assign err_underrun = err_q;
    assign m_valid      = (buf_cnt_q != 2'd0);
    assign m_data       = head_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader: an 18-bit and a 9-bit instance share one FIFO model;
// each stream is scored against the words the FIFO holds, in order.
module tb_sync_fifo_stream_reader;
    localparam int LW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, fifo_empty, fifo_underrun, m_ready;
    logic [LW-1:0] len;
    logic [17:0]   fifo_dout;

    logic          busy, done, err, fifo_re, m_valid;
    logic [LW-1:0] rd_count;
    logic [17:0]   m_data;
    logic [1:0]    dbg;
    logic          busy9, done9, err9, fifo_re9, m_valid9;
    logic [LW-1:0] rd_count9;
    logic [8:0]    m_data9;
    logic [1:0]    dbg9;

    sync_fifo_stream_reader #(.DATA_WIDTH(18), .LEN_WIDTH(LW)) dut (
        .clock0(clk), .rst_ptr_n(rst_n), .start(start), .len(len),
        .busy(busy), .done(done), .rd_count(rd_count), .err_underrun(err),
        .fifo_re(fifo_re), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_underrun(fifo_underrun), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .dbg_state_o(dbg)
    );

    sync_fifo_stream_reader #(.DATA_WIDTH(9), .LEN_WIDTH(LW)) dut9 (
        .clock0(clk), .rst_ptr_n(rst_n), .start(start), .len(len),
        .busy(busy9), .done(done9), .rd_count(rd_count9), .err_underrun(err9),
        .fifo_re(fifo_re9), .fifo_dout(fifo_dout[8:0]), .fifo_empty(fifo_empty),
        .fifo_underrun(fifo_underrun), .m_valid(m_valid9), .m_data(m_data9),
        .m_ready(m_ready), .dbg_state_o(dbg9)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [17:0] fifo_q[$];
    logic [17:0] exp_q[$];
    logic [8:0]  exp9_q[$];

    int re_cnt, re9_cnt, hs_cnt, hs9_cnt, done_cnt, done9_cnt;
    int first_re_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc, start_cyc;
    logic        prev_stall;
    logic [17:0] prev_data;

    // FIFO model: a read at an edge presents its word on fifo_dout for the next cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re === 1'b1 && fifo_q.size() != 0) begin
            fifo_dout  <= fifo_q.pop_front();
            fifo_empty <= (fifo_q.size() == 0);
        end
    end

    // Scoreboard: looks at the cycle ahead of each edge, away from the edge itself.
    always @(negedge clk) begin
        logic [17:0] e;
        logic [8:0]  e9;
        if (fifo_re === 1'b1 || fifo_re9 === 1'b1) begin
            checks++;
            if (fifo_empty !== 1'b0 || rst_n !== 1'b1) begin
                errors++;
                $display("FAIL re_illegal: fifo_re=%b fifo_re9=%b empty=%b rst_n=%b t=%0t",
                         fifo_re, fifo_re9, fifo_empty, rst_n, $time);
            end
        end
        if (rst_n === 1'b1) begin
            if (fifo_re === 1'b1) begin
                re_cnt++;
                if (first_re_cyc < 0) first_re_cyc = cyc;
            end
            if (fifo_re9 === 1'b1) re9_cnt++;
            if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h",
                             m_valid, m_data, prev_data);
                end
            end
            prev_stall = (m_valid === 1'b1 && m_ready === 1'b0);
            prev_data  = m_data;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra: got %h, no word expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL stream_data: got %h, expected %h", m_data, e);
                    end
                end
                hs_cnt++;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            if (m_valid9 === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (exp9_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream9_extra: got %h, no word expected", m_data9);
                end else begin
                    e9 = exp9_q.pop_front();
                    if (m_data9 !== e9) begin
                        errors++;
                        $display("FAIL stream9_data: got %h, expected %h", m_data9, e9);
                    end
                end
                hs9_cnt++;
            end
            if (re_cnt - hs_cnt > 2) begin
                checks++;
                errors++;
                $display("FAIL outstanding: reads %0d minus handshakes %0d exceeds 2", re_cnt, hs_cnt);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done9 === 1'b1) done9_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        re_cnt = 0; re9_cnt = 0; hs_cnt = 0; hs9_cnt = 0; done_cnt = 0; done9_cnt = 0;
        first_re_cyc = -1; first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
        done_cyc = -1; prev_stall = 1'b0;
    endtask

    task automatic flush();
        fifo_q.delete();
        exp_q.delete();
        exp9_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic push_word(input logic [17:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic load_fifo(input int n);
        for (int i = 0; i < n; i++) push_word(18'($urandom));
    endtask

    // The stream must carry exactly the first n words the FIFO currently holds.
    task automatic expect_head(input int n);
        logic [17:0] w;
        for (int i = 0; i < n; i++) begin
            w = fifo_q[i];
            exp_q.push_back(w);
            exp9_q.push_back(w[8:0]);
        end
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = LW'(l);
        tick();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        tick();
    endtask

    task automatic test_reset();
        flush();
        load_fifo(4);
        clear_stats();
        start = 1'b1; len = LW'(5); m_ready = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks += 2;
            if ({busy, done, rd_count, err, fifo_re, m_valid, m_data, dbg} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: %h, required 0",
                         {busy, done, rd_count, err, fifo_re, m_valid, m_data, dbg});
            end
            if ({busy9, done9, rd_count9, err9, fifo_re9, m_valid9, m_data9, dbg9} !== '0) begin
                errors++;
                $display("FAIL reset_outputs9: %h, required 0",
                         {busy9, done9, rd_count9, err9, fifo_re9, m_valid9, m_data9, dbg9});
            end
        end
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (fifo_q.size() != 4) begin
            errors++;
            $display("FAIL reset_no_read: fifo holds %0d words, required 4", fifo_q.size());
        end
    endtask

    task automatic test_straight_drain();
        flush();
        load_fifo(50);
        expect_head(50);
        clear_stats();
        m_ready = 1'b1;
        do_start(50);
        wait_done(200, "straight");
        repeat (3) tick();
        checks += 11;
        if (first_re_cyc != start_cyc) begin
            errors++; $display("FAIL straight_re_latency: cycle %0d, required %0d", first_re_cyc, start_cyc);
        end
        if (first_valid_cyc != start_cyc + 2) begin
            errors++; $display("FAIL straight_valid_latency: cycle %0d, required %0d", first_valid_cyc, start_cyc + 2);
        end
        if (last_hs_cyc - first_hs_cyc != 49) begin
            errors++; $display("FAIL straight_throughput: span %0d, required 49", last_hs_cyc - first_hs_cyc);
        end
        if (hs_cnt != 50 || hs9_cnt != 50) begin
            errors++; $display("FAIL straight_handshakes: %0d/%0d, required 50", hs_cnt, hs9_cnt);
        end
        if (re_cnt != 50 || re9_cnt != 50) begin
            errors++; $display("FAIL straight_reads: %0d/%0d, required 50", re_cnt, re9_cnt);
        end
        if (done_cnt != 1 || done9_cnt != 1) begin
            errors++; $display("FAIL straight_done_count: %0d/%0d, required 1", done_cnt, done9_cnt);
        end
        if (done_cyc != last_hs_cyc + 1) begin
            errors++; $display("FAIL straight_done_timing: cycle %0d, required %0d", done_cyc, last_hs_cyc + 1);
        end
        if (rd_count !== LW'(50)) begin
            errors++; $display("FAIL straight_rd_count: %0d, required 50", rd_count);
        end
        if (rd_count9 !== LW'(50)) begin
            errors++; $display("FAIL straight_rd_count9: %0d, required 50", rd_count9);
        end
        if (exp_q.size() != 0 || exp9_q.size() != 0) begin
            errors++; $display("FAIL straight_missing: %0d/%0d words undelivered, required 0", exp_q.size(), exp9_q.size());
        end
        if (busy !== 1'b0 || dbg !== 2'd0) begin
            errors++; $display("FAIL straight_idle: busy=%b state=%0d, required 0/0", busy, dbg);
        end
    endtask

    task automatic test_back_pressure();
        int pat[4] = '{1, 0, 0, 1};
        int i = 0;
        flush();
        load_fifo(24);
        expect_head(20);
        clear_stats();
        m_ready = 1'b1;
        do_start(20);
        while (done_cnt == 0 && i < 300) begin
            m_ready = pat[i % 4][0];
            start   = (i == 7);
            len     = (i == 7) ? LW'(3) : LW'(20);
            tick();
            i++;
        end
        start = 1'b0;
        m_ready = 1'b1;
        tick();
        checks += 4;
        if (done_cnt != 1) begin
            errors++; $display("FAIL bp_done: count %0d, required 1", done_cnt);
        end
        if (hs_cnt != 20 || re_cnt != 20) begin
            errors++; $display("FAIL bp_counts: handshakes %0d reads %0d, required 20/20", hs_cnt, re_cnt);
        end
        if (rd_count !== LW'(20)) begin
            errors++; $display("FAIL bp_rd_count: %0d, required 20", rd_count);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL bp_missing: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_random_ready();
        int l = $urandom_range(10, 40);
        int i = 0;
        flush();
        load_fifo(l + 5);
        expect_head(l);
        clear_stats();
        m_ready = 1'b1;
        do_start(l);
        while (done_cnt == 0 && i < 400) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        m_ready = 1'b1;
        tick();
        checks += 2;
        if (rd_count !== LW'(l) || hs_cnt != l) begin
            errors++; $display("FAIL rand_count: rd_count %0d handshakes %0d, required %0d", rd_count, hs_cnt, l);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rand_missing: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_empty_stall();
        logic [17:0] w[8];
        flush();
        for (int i = 0; i < 8; i++) begin
            w[i] = 18'($urandom);
            exp_q.push_back(w[i]);
            exp9_q.push_back(w[i][8:0]);
        end
        for (int i = 0; i < 3; i++) push_word(w[i]);
        clear_stats();
        m_ready = 1'b1;
        do_start(8);
        repeat (5) tick();
        @(negedge clk);
        checks += 2;
        if (m_valid !== 1'b0 || hs_cnt != 3) begin
            errors++; $display("FAIL stall_drained: valid=%b handshakes=%0d, required 0/3", m_valid, hs_cnt);
        end
        if (busy !== 1'b1) begin
            errors++; $display("FAIL stall_busy: busy=%b, required 1", busy);
        end
        tick();
        for (int i = 3; i < 8; i++) push_word(w[i]);
        wait_done(100, "stall");
        checks += 2;
        if (rd_count !== LW'(8) || re_cnt != 8) begin
            errors++; $display("FAIL stall_counts: rd_count %0d reads %0d, required 8/8", rd_count, re_cnt);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL stall_missing: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_edge_lengths();
        flush();
        load_fifo(3);
        clear_stats();
        m_ready = 1'b1;
        do_start(0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || done9 !== 1'b1) begin
            errors++; $display("FAIL len0_done: done=%b done9=%b, required 1", done, done9);
        end
        #1;
        repeat (2) tick();
        checks += 2;
        if (re_cnt != 0 || fifo_q.size() != 3) begin
            errors++; $display("FAIL len0_reads: %0d reads, fifo %0d, required 0 reads, fifo 3", re_cnt, fifo_q.size());
        end
        if (done_cnt != 1 || rd_count !== '0) begin
            errors++; $display("FAIL len0_status: done count %0d rd_count %0d, required 1/0", done_cnt, rd_count);
        end
        expect_head(1);
        clear_stats();
        do_start(1);
        wait_done(20, "len1");
        checks += 2;
        if (re_cnt != 1 || hs_cnt != 1 || fifo_q.size() != 2) begin
            errors++; $display("FAIL len1_counts: reads %0d handshakes %0d fifo %0d, required 1/1/2", re_cnt, hs_cnt, fifo_q.size());
        end
        if (rd_count !== LW'(1) || exp_q.size() != 0) begin
            errors++; $display("FAIL len1_status: rd_count %0d left %0d, required 1/0", rd_count, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int n = 0;
        flush();
        load_fifo(40);
        expect_head(30);
        clear_stats();
        m_ready = 1'b1;
        do_start(30);
        while (hs_cnt < 10 && n < 100) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        checks += 3;
        if (hs_cnt != 10) begin
            errors++; $display("FAIL abort_point: %0d handshakes, required 10", hs_cnt);
        end
        if ({busy, done, rd_count, err, fifo_re, m_valid, m_data, dbg} !== '0) begin
            errors++; $display("FAIL abort_outputs: %h, required 0",
                               {busy, done, rd_count, err, fifo_re, m_valid, m_data, dbg});
        end
        if (done_cnt != 0) begin
            errors++; $display("FAIL abort_done: %0d done pulses, required 0", done_cnt);
        end
        #1;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp9_q.delete();
        expect_head(5);
        clear_stats();
        tick();
        do_start(5);
        wait_done(50, "after_abort");
        checks += 2;
        if (rd_count !== LW'(5) || hs_cnt != 5) begin
            errors++; $display("FAIL after_abort_counts: rd_count %0d handshakes %0d, required 5/5", rd_count, hs_cnt);
        end
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL after_abort_missing: %0d words undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_underrun();
        flush();
        load_fifo(20);
        expect_head(20);
        clear_stats();
        m_ready = 1'b1;
        do_start(20);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_initial: %b, required 0", err);
        end
        #1;
        repeat (4) tick();
        fifo_underrun = 1'b1;
        tick();
        fifo_underrun = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || err9 !== 1'b1) begin
            errors++; $display("FAIL err_set: %b/%b, required 1", err, err9);
        end
        #1;
        wait_done(100, "underrun");
        checks += 2;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky: %b, required 1", err);
        end
        if (hs_cnt != 20 || exp_q.size() != 0) begin
            errors++; $display("FAIL err_data: handshakes %0d left %0d, required 20/0", hs_cnt, exp_q.size());
        end
        do_start(0);
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear: %b, required 0", err);
        end
        #1;
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; m_ready = 1'b1;
        fifo_underrun = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
        clear_stats();
        test_reset();
        test_straight_drain();
        test_back_pressure();
        test_random_ready();
        test_empty_stall();
        test_edge_lengths();
        test_abort();
        test_underrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
